// File: rtl/wave_switch_ctrl.sv
// ---------------------------------------------------------------------------
// wave_switch_ctrl
//
// Owns the wave_mux select and applies a gain ramp to the mux output so that
// waveform changes do not click. The gain fades out to silence, the select
// changes while the output is silent, and the gain fades back in. Requests
// use a valid/ready handshake. The ramp advances one step per sample tick.
//
// Optional build macro: WAVE_CTRL_AUTO_CYCLE_EN
//   When defined, adds i_auto_en and a dwell counter. While idle with
//   i_auto_en high, the controller steps to the next waveform after
//   DWELL_TICKS sample ticks.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_sample_tick  one-cycle strobe at the audio sample rate
//   i_req_valid    waveform change request
//   i_req_sel      requested waveform (0 sine, 1 saw, 2 square, 3 tri, 4 noise)
//   o_req_ready    request accepted when valid && ready (high only in IDLE)
//   o_sel          select driven to wave_mux
//   i_mux_data     wave_mux output sample, signed
//   o_data         gain-scaled sample, signed, updated one cycle after a tick
//   o_busy         high in every state except IDLE
//   o_err          one-cycle pulse when a request with sel > 4 is accepted
//   i_auto_en      auto-cycle enable (WAVE_CTRL_AUTO_CYCLE_EN builds only)
// ---------------------------------------------------------------------------
module wave_switch_ctrl #(
    parameter int GAIN_W      = 8,
    parameter int FADE_STEP   = 16,
    parameter int DWELL_TICKS = 48000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sample_tick,
    input  logic        i_req_valid,
    input  logic [2:0]  i_req_sel,
    output logic        o_req_ready,
    output logic [2:0]  o_sel,
    input  logic [15:0] i_mux_data,
    output logic [15:0] o_data,
    output logic        o_busy,
    output logic        o_err
`ifdef WAVE_CTRL_AUTO_CYCLE_EN
    ,
    input  logic        i_auto_en
`endif
);

    localparam int FULL = 2 ** GAIN_W;
    localparam logic [GAIN_W:0] FULL_G = (GAIN_W + 1)'(FULL);
    localparam logic [GAIN_W:0] STEP_G = (GAIN_W + 1)'(FADE_STEP);
    localparam logic [2:0]      SEL_MAX = 3'd4;

    // Product width: 16-bit signed sample times a (GAIN_W+1)-bit unsigned
    // gain carried as a (GAIN_W+2)-bit signed operand.
    localparam int PW = 16 + GAIN_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        SWITCH,
        FADE_IN
    } state_t;

    state_t            state_reg;
    logic [GAIN_W:0]   gain_reg;
    logic [2:0]        pending_sel_reg;

    // -----------------------------------------------------------------------
    // Gain scaling. Taking bits [GAIN_W +: 16] of the full product is the
    // arithmetic shift right by GAIN_W followed by truncation to 16 bits.
    // -----------------------------------------------------------------------
    logic signed [PW-1:0] data_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] product;
    logic                 product_unused;

    assign data_ext       = PW'($signed(i_mux_data));
    assign gain_ext       = PW'({1'b0, gain_reg});
    assign product        = data_ext * gain_ext;
    assign product_unused = ^{product[PW-1:GAIN_W+16], product[GAIN_W-1:0]};

    // Saturating ramp steps, written to avoid wrapping the gain register.
    logic [GAIN_W:0] gain_down;
    logic [GAIN_W:0] gain_up;

    assign gain_down = (gain_reg > STEP_G) ? (gain_reg - STEP_G) : '0;
    assign gain_up   = (gain_reg >= (FULL_G - STEP_G)) ? FULL_G : (gain_reg + STEP_G);

    // -----------------------------------------------------------------------
    // Internal auto-cycle request
    // -----------------------------------------------------------------------
    logic       auto_req;
    logic [2:0] auto_sel;

`ifdef WAVE_CTRL_AUTO_CYCLE_EN
    localparam int CNT_W = $clog2(DWELL_TICKS + 1);
    localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL_TICKS);

    logic [CNT_W-1:0] dwell_cnt_reg;

    // Counts idle ticks and saturates at DWELL_TICKS; leaving IDLE (which
    // the resulting request causes) or dropping the enable clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dwell_cnt_reg <= '0;
        end else if ((state_reg != IDLE) || !i_auto_en) begin
            dwell_cnt_reg <= '0;
        end else if (i_sample_tick && (dwell_cnt_reg != DWELL_C)) begin
            dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
        end
    end

    assign auto_req = i_auto_en && (dwell_cnt_reg == DWELL_C);
    assign auto_sel = (o_sel == SEL_MAX) ? 3'd0 : (o_sel + 3'd1);
`else
    logic dwell_unused;

    assign auto_req     = 1'b0;
    assign auto_sel     = 3'd0;
    assign dwell_unused = (DWELL_TICKS != 0);
`endif

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // Power-up starts in FADE_IN at zero gain so the first output
            // samples ramp up instead of popping.
            state_reg       <= FADE_IN;
            gain_reg        <= '0;
            pending_sel_reg <= 3'd0;
            o_sel           <= 3'd0;
            o_data          <= 16'd0;
            o_err           <= 1'b0;
            o_req_ready     <= 1'b0;
            o_busy          <= 1'b1;
        end else begin
            o_err <= 1'b0;

            // Uses the gain before this tick's ramp update.
            if (i_sample_tick) begin
                o_data <= product[GAIN_W +: 16];
            end

            case (state_reg)
                IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        if (i_req_sel > SEL_MAX) begin
                            o_err <= 1'b1;
                        end else if (i_req_sel != o_sel) begin
                            pending_sel_reg <= i_req_sel;
                            state_reg       <= FADE_OUT;
                            o_req_ready     <= 1'b0;
                            o_busy          <= 1'b1;
                        end
                    end else if (auto_req) begin
                        pending_sel_reg <= auto_sel;
                        state_reg       <= FADE_OUT;
                        o_req_ready     <= 1'b0;
                        o_busy          <= 1'b1;
                    end
                end

                FADE_OUT: begin
                    if (gain_reg == '0) begin
                        state_reg <= SWITCH;
                    end else if (i_sample_tick) begin
                        gain_reg <= gain_down;
                    end
                end

                // Gain is zero here, so the select changes under silence.
                SWITCH: begin
                    o_sel     <= pending_sel_reg;
                    state_reg <= FADE_IN;
                end

                FADE_IN: begin
                    if (gain_reg == FULL_G) begin
                        state_reg   <= IDLE;
                        o_req_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end else if (i_sample_tick) begin
                        gain_reg <= gain_up;
                    end
                end

                default: begin
                    state_reg   <= FADE_IN;
                    gain_reg    <= '0;
                    o_req_ready <= 1'b0;
                    o_busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wave_switch_ctrl
//
// Self-checking bench for wave_switch_ctrl. Expected output samples are
// pushed to a scoreboard queue as each tick is driven and popped when the
// registered output appears one cycle later.
// ---------------------------------------------------------------------------
module tb_wave_switch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        req_valid;
    logic [2:0]  req_sel;
    logic        req_ready;
    logic [2:0]  sel;
    logic [15:0] mux_data;
    logic [15:0] data;
    logic        busy;
    logic        err;
`ifdef WAVE_CTRL_AUTO_CYCLE_EN
    logic        auto_en;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    wave_switch_ctrl #(
        .GAIN_W      (8),
        .FADE_STEP   (16),
        .DWELL_TICKS (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sample_tick (tick),
        .i_req_valid   (req_valid),
        .i_req_sel     (req_sel),
        .o_req_ready   (req_ready),
        .o_sel         (sel),
        .i_mux_data    (mux_data),
        .o_data        (data),
        .o_busy        (busy),
        .o_err         (err)
`ifdef WAVE_CTRL_AUTO_CYCLE_EN
        ,
        .i_auto_en     (auto_en)
`endif
    );

    // Reference scaling: (signed sample * gain) >>> 8, truncated to 16 bits.
    function automatic logic [15:0] scale(input logic [15:0] d, input int g);
        int p;
        p = $signed(d) * g;
        p = p >>> 8;
        return p[15:0];
    endfunction

    // Drives one sample tick; returns at the negedge after the tick's edge.
    task automatic drive_tick(input logic [15:0] d);
        @(negedge clk);
        mux_data = d;
        tick     = 1'b1;
        @(negedge clk);
        tick     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle request pulse; returns at the negedge after the accept edge.
    task automatic pulse_req(input logic [2:0] s);
        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = s;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        tick      = 1'b0;
        req_valid = 1'b0;
        req_sel   = 3'd0;
        mux_data  = 16'h1000;
`ifdef WAVE_CTRL_AUTO_CYCLE_EN
        auto_en   = 1'b0;
`endif
        idle_cycles(3);
        tests_run++;
        $display("[TB] reset busy=%b ready=%b sel=%0d data=%h err=%b", busy, req_ready, sel, data, err);
        if ({busy, req_ready, sel, data, err} !== {1'b1, 1'b0, 3'd0, 16'h0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b ready=%b sel=%0d data=%h err=%b required 1 0 0 0000 0",
                     busy, req_ready, sel, data, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_power_up_fade();
        logic [15:0] e;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(16'(k * 256));
            drive_tick(16'h1000);
            e = exp_q.pop_front();
            tests_run++;
            $display("[TB] power_up tick %0d data=%h exp=%h busy=%b", k, data, e, busy);
            if (data !== e || busy !== 1'b1 || req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL power_up_ramp: tick %0d got data=%h busy=%b ready=%b required %h 1 0",
                         k, data, busy, req_ready, e);
            end
            idle_cycles(3);
        end
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || sel !== 3'd0) begin
            tests_failed++;
            $display("FAIL power_up_idle: got ready=%b busy=%b sel=%0d required 1 0 0", req_ready, busy, sel);
        end
        exp_q.push_back(16'h1000);
        drive_tick(16'h1000);
        e = exp_q.pop_front();
        tests_run++;
        $display("[TB] power_up full data=%h exp=%h", data, e);
        if (data !== e) begin
            tests_failed++;
            $display("FAIL power_up_full: got %h required %h", data, e);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_switch();
        logic [15:0] e;
        pulse_req(3'd2);
        tests_run++;
        if (req_ready !== 1'b0 || busy !== 1'b1 || sel !== 3'd0) begin
            tests_failed++;
            $display("FAIL switch_accept: got ready=%b busy=%b sel=%0d required 0 1 0", req_ready, busy, sel);
        end
        for (int j = 0; j < 16; j++) begin
            exp_q.push_back(16'h1000 - 16'(j * 256));
            drive_tick(16'h1000);
            e = exp_q.pop_front();
            tests_run++;
            $display("[TB] fade_out tick %0d data=%h exp=%h sel=%0d", j, data, e, sel);
            if (data !== e || sel !== 3'd0 || req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL switch_fade_out: tick %0d got data=%h sel=%0d ready=%b required %h 0 0",
                         j, data, sel, req_ready, e);
            end
            idle_cycles(3);
        end
        tests_run++;
        if (sel !== 3'd2 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL switch_sel: got sel=%0d busy=%b required 2 1", sel, busy);
        end
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(16'(k * 256));
            drive_tick(16'h1000);
            e = exp_q.pop_front();
            tests_run++;
            $display("[TB] fade_in tick %0d data=%h exp=%h", k, data, e);
            if (data !== e || req_ready !== 1'b0 || sel !== 3'd2) begin
                tests_failed++;
                $display("FAIL switch_fade_in: tick %0d got data=%h ready=%b sel=%0d required %h 0 2",
                         k, data, req_ready, sel, e);
            end
            idle_cycles(3);
        end
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL switch_done: got ready=%b busy=%b required 1 0", req_ready, busy);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_scaling();
        logic [15:0] e;
        logic [15:0] d;
        pulse_req(3'd1);
        for (int j = 0; j < 16; j++) begin
            d = (j == 8) ? 16'hF000 : 16'($urandom);
            e = (j == 8) ? 16'hF800 : scale(d, 256 - 16 * j);
            exp_q.push_back(e);
            drive_tick(d);
            e = exp_q.pop_front();
            tests_run++;
            $display("[TB] scale_out tick %0d in=%h data=%h exp=%h", j, d, data, e);
            if (data !== e) begin
                tests_failed++;
                $display("FAIL scale_fade_out: tick %0d in=%h got %h required %h", j, d, data, e);
            end
            idle_cycles(3);
        end
        for (int k = 0; k < 16; k++) begin
            d = 16'($urandom);
            exp_q.push_back(scale(d, 16 * k));
            drive_tick(d);
            e = exp_q.pop_front();
            tests_run++;
            $display("[TB] scale_in tick %0d in=%h data=%h exp=%h", k, d, data, e);
            if (data !== e) begin
                tests_failed++;
                $display("FAIL scale_fade_in: tick %0d in=%h got %h required %h", k, d, data, e);
            end
            idle_cycles(3);
        end
        exp_q.push_back(16'h7FFF);
        exp_q.push_back(16'h8000);
        drive_tick(16'h7FFF);
        e = exp_q.pop_front();
        tests_run++;
        $display("[TB] scale_full in=7fff data=%h exp=%h", data, e);
        if (data !== e) begin
            tests_failed++;
            $display("FAIL scale_full_pos: got %h required %h", data, e);
        end
        drive_tick(16'h8000);
        e = exp_q.pop_front();
        tests_run++;
        $display("[TB] scale_full in=8000 data=%h exp=%h", data, e);
        if (data !== e) begin
            tests_failed++;
            $display("FAIL scale_full_neg: got %h required %h", data, e);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_err_noop();
        logic [2:0] bad_sel [2];
        bad_sel[0] = 3'd5;
        bad_sel[1] = 3'd7;
        for (int i = 0; i < 2; i++) begin
            pulse_req(bad_sel[i]);
            tests_run++;
            $display("[TB] err req sel=%0d err=%b sel=%0d busy=%b", bad_sel[i], err, sel, busy);
            if (err !== 1'b1 || sel !== 3'd1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL err_pulse: sel %0d got err=%b sel=%0d busy=%b required 1 1 0",
                         bad_sel[i], err, sel, busy);
            end
            @(negedge clk);
            tests_run++;
            if (err !== 1'b0) begin
                tests_failed++;
                $display("FAIL err_one_cycle: got err=%b required 0", err);
            end
        end
        pulse_req(3'd1);
        idle_cycles(2);
        tests_run++;
        $display("[TB] noop req sel=1 busy=%b ready=%b err=%b sel=%0d", busy, req_ready, err, sel);
        if (busy !== 1'b0 || req_ready !== 1'b1 || err !== 1'b0 || sel !== 3'd1) begin
            tests_failed++;
            $display("FAIL noop_same_sel: got busy=%b ready=%b err=%b sel=%0d required 0 1 0 1",
                     busy, req_ready, err, sel);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_hold_off_and_reset();
        logic [15:0] e;
        pulse_req(3'd4);
        for (int j = 0; j < 16; j++) begin
            drive_tick(16'h1000);
            idle_cycles(3);
        end
        // Request held through the whole fade-in.
        req_valid = 1'b1;
        req_sel   = 3'd0;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(16'(k * 256));
            drive_tick(16'h1000);
            e = exp_q.pop_front();
            tests_run++;
            $display("[TB] held fade_in tick %0d data=%h exp=%h ready=%b", k, data, e, req_ready);
            if (data !== e || req_ready !== 1'b0 || sel !== 3'd4) begin
                tests_failed++;
                $display("FAIL hold_off: tick %0d got data=%h ready=%b sel=%0d required %h 0 4",
                         k, data, req_ready, sel, e);
            end
            if (k < 15) idle_cycles(3);
        end
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_first_idle: got ready=%b busy=%b required 1 0", req_ready, busy);
        end
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_accept: got ready=%b busy=%b required 0 1", req_ready, busy);
        end
        for (int j = 0; j < 5; j++) begin
            drive_tick(16'h1000);
            idle_cycles(1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        $display("[TB] mid_fade reset sel=%0d data=%h busy=%b ready=%b", sel, data, busy, req_ready);
        if ({sel, data, busy, req_ready} !== {3'd0, 16'h0000, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_fade_reset: got sel=%0d data=%h busy=%b ready=%b required 0 0000 1 0",
                     sel, data, busy, req_ready);
        end
        idle_cycles(2);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(16'(k * 256));
            drive_tick(16'h1000);
            e = exp_q.pop_front();
            tests_run++;
            $display("[TB] post_reset tick %0d data=%h exp=%h", k, data, e);
            if (data !== e || sel !== 3'd0) begin
                tests_failed++;
                $display("FAIL post_reset_ramp: tick %0d got data=%h sel=%0d required %h 0", k, data, sel, e);
            end
            idle_cycles(3);
        end
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got ready=%b busy=%b required 1 0", req_ready, busy);
        end
    endtask

`ifdef WAVE_CTRL_AUTO_CYCLE_EN
    // -----------------------------------------------------------------------
    task automatic test_auto_cycle();
        logic [2:0] sel_q[$];
        logic [2:0] last_sel;
        logic [2:0] es;
        sel_q.push_back(3'd1);
        sel_q.push_back(3'd2);
        sel_q.push_back(3'd3);
        sel_q.push_back(3'd4);
        sel_q.push_back(3'd0);
        last_sel = sel;
        auto_en  = 1'b1;
        for (int n = 0; n < 800 && sel_q.size() != 0; n++) begin
            drive_tick(16'h1000);
            if (sel !== last_sel) begin
                es = sel_q.pop_front();
                tests_run++;
                $display("[TB] auto sel change %0d -> %0d exp=%0d", last_sel, sel, es);
                if (sel !== es) begin
                    tests_failed++;
                    $display("FAIL auto_sel: got %0d required %0d", sel, es);
                end
                last_sel = sel;
            end
            idle_cycles(1);
        end
        auto_en = 1'b0;
        tests_run++;
        if (sel_q.size() != 0) begin
            tests_failed++;
            $display("FAIL auto_timeout: got %0d changes pending required 0", sel_q.size());
        end
    endtask
`endif

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_power_up_fade();
        test_switch();
        test_scaling();
        test_err_noop();
        test_hold_off_and_reset();
`ifdef WAVE_CTRL_AUTO_CYCLE_EN
        test_auto_cycle();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d tests run", tests_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wave_switch_ctrl.md
Name: wave_switch_ctrl

Overview:
Controller that drives the select input of the wave_mux and applies a gain ramp to the mux output. The ramp fades out before each waveform change and fades back in after it, so switching waveforms does not click. It sits between the front-panel or MIDI waveform-select logic and the output stage, and it owns the mux select exclusively. Requests use a valid/ready handshake; the gain ramp advances once per sample tick.

Parameters:
GAIN_W, 8, gain fraction bits; full-scale gain FULL = 2**GAIN_W (256)
FADE_STEP, 16, gain change per sample tick during a fade; must be 1..FULL
DWELL_TICKS, 48000, sample ticks per waveform in auto-cycle mode (optional feature only)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_sample_tick  in  1  one-cycle strobe at the audio sample rate
i_req_valid  in  1  waveform change request
i_req_sel  in  3  requested waveform: 0 sine, 1 saw, 2 square, 3 tri, 4 noise
o_req_ready  out  1  request accepted when valid && ready
o_sel  out  3  select to wave_mux i_sel
i_mux_data  in  16  wave_mux o_data, signed two's complement
o_data  out  16  gain-scaled sample, signed
o_busy  out  1  high in every state except IDLE
o_err  out  1  one-cycle pulse when a request with sel > 4 is accepted
i_auto_en  in  1  auto-cycle enable (port exists only with WAVE_CTRL_AUTO_CYCLE_EN)

Behaviour:
- Reset (asynchronous, on i_rst_n low):
  - State FADE_IN, gain = 0, o_sel = 0, o_data = 0, o_err = 0, o_req_ready = 0, o_busy = 1.
  - The power-up fade-in suppresses the startup pop.
- Gain register: GAIN_W+1 bits wide, range 0..FULL.
- FSM states: IDLE, FADE_OUT, SWITCH, FADE_IN.
- IDLE:
  - o_req_ready = 1. Gain holds at FULL, so the output is a bit-exact passthrough.
  - Accept with req_sel in 0..4 and req_sel != o_sel: latch pending_sel, go to FADE_OUT.
  - Accept with req_sel == o_sel: no-op, stay in IDLE.
  - Accept with req_sel > 4: o_err pulses for one cycle, stay in IDLE, o_sel unchanged.
- FADE_OUT: on each tick, gain = max(gain - FADE_STEP, 0). The first cycle with gain == 0 moves to SWITCH.
- SWITCH: lasts exactly one cycle. o_sel <= pending_sel, then go to FADE_IN.
- FADE_IN: on each tick, gain = min(gain + FADE_STEP, FULL). The first cycle with gain == FULL moves to IDLE.
- Fade duration: ceil(FULL/FADE_STEP) ticks in each direction (16 ticks with the defaults).
- o_req_ready is 0 outside IDLE. A requester holds its request until it is accepted. The controller never queues requests.
- o_data:
  - Registered. Updated only on cycles where i_sample_tick = 1.
  - Value: (signed i_mux_data * gain) >>> GAIN_W, truncated to 16 bits.
  - Uses the gain value before that tick's update.
  - Latency: 1 cycle after the tick.
  - Between ticks o_data holds its value.
- o_sel changes only in SWITCH, when gain is 0, so the output is already silent at the change.
- i_sample_tick asserted continuously: one ramp step per cycle. This is legal.
- i_req_valid is ignored while reset is asserted.
- Reset asserted mid-fade: the controller returns to the reset state immediately and the pending request is discarded.

Optional Feature:
WAVE_CTRL_AUTO_CYCLE_EN
- Defined:
  - Adds port i_auto_en and a tick counter.
  - In IDLE with i_auto_en = 1, the counter counts ticks. When it reaches DWELL_TICKS, the controller issues an internal request for (o_sel == 4 ? 0 : o_sel + 1).
  - An external request in the same cycle takes priority.
  - The counter clears on leaving IDLE and whenever i_auto_en = 0.
- Undefined: no port, no counter. Waveforms change only on external requests.

Test Plan:
1. Reset release; i_mux_data = 16'h1000; tick every 4 clocks -> o_busy = 1 for 16 ticks, o_data ramps 0, 16'h0100, 16'h0200, ... and reaches 16'h1000 at gain FULL; o_req_ready rises after the ramp; o_sel = 0.
2. In IDLE, request sel = 2 -> 16-tick fade-out; o_sel goes 0 -> 2 only after o_data = 0; 16-tick fade-in; o_req_ready = 0 throughout.
3. Gain mid-ramp at 128 with i_mux_data = 16'hF000 -> o_data = 16'hF800; at gain FULL with 16'h7FFF -> o_data = 16'h7FFF.
4. Request sel = 5 in IDLE -> o_err pulses for one cycle; o_sel and o_busy unchanged. Request sel equal to the current o_sel -> accepted, no fade.
5. Request asserted during FADE_IN -> held off (ready = 0), accepted on the first IDLE cycle. Reset asserted mid-FADE_OUT -> o_sel = 0, gain = 0, FADE_IN begins.
6. With WAVE_CTRL_AUTO_CYCLE_EN, DWELL_TICKS = 4, i_auto_en = 1 -> o_sel sequence 0, 1, 2, 3, 4, 0, each waveform held for 4 idle ticks plus the fades.
